// File: rtl/auc_rbg.sv
// auc_rbg: gathers WIDTH-bit candidates from an EW-bit entropy stream with a repetition-count health test.
// Ports: clk, rst (sync, active-high), rbg_req start pulse, ent_vld/ent_din entropy input,
// rand_vld retake-done from auc_rand, rand_en first-candidate pulse, rand_din candidate,
// rbg_busy not-idle flag, rbg_err sticky health failure.
module auc_rbg #(
  parameter int WIDTH   = 256,
  parameter int EW      = 32,
  parameter int RCT_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rbg_req,
  input  logic             ent_vld,
  input  logic [EW-1:0]    ent_din,
  input  logic             rand_vld,
  output logic             rand_en,
  output logic [WIDTH-1:0] rand_din,
  output logic             rbg_busy,
  output logic             rbg_err
);
  localparam int NW = WIDTH / EW;
  localparam int CW = NW > 1 ? $clog2(NW) : 1;
  typedef enum logic [1:0] {IDLE, FILL, REFILL} state_e;
  state_e              state_q;
  logic [WIDTH-EW-1:0] col_q;
  logic [CW-1:0]       cnt_q;
  logic [3:0]          rep_q, rep_d;
  logic [EW-1:0]       last_q;
  logic                rand_en_q, err_q;
  logic [WIDTH-1:0]    rand_din_q, word_d;
  logic                acc, fail, full;
  always_comb begin
    acc    = ent_vld && state_q != IDLE;
    // rep_q == 0 marks last_q as invalid, so the next word always starts a fresh run
    rep_d  = (rep_q != 4'd0 && ent_din == last_q) ? rep_q + 4'd1 : 4'd1;
    fail   = acc && rep_d == 4'(RCT_MAX);
    full   = acc && !fail && cnt_q == CW'(NW - 1);
    word_d = {col_q, ent_din};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      cnt_q      <= '0;
      rep_q      <= '0;
      last_q     <= '0;
      rand_en_q  <= 1'b0;
      rand_din_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rand_en_q <= 1'b0;
      if (state_q == IDLE) begin
        if (rbg_req) begin
          state_q <= FILL;
          col_q   <= '0;
          cnt_q   <= '0;
          rep_q   <= '0;
          last_q  <= '0;
          err_q   <= 1'b0;
        end
      end else if (state_q == REFILL && rand_vld) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (fail) begin
        cnt_q <= '0;
        rep_q <= '0;
        err_q <= 1'b1;
      end else if (acc) begin
        col_q  <= word_d[WIDTH-EW-1:0];
        cnt_q  <= full ? '0 : cnt_q + CW'(1);
        rep_q  <= rep_d;
        last_q <= ent_din;
        if (full) begin
          rand_din_q <= word_d;
          rand_en_q  <= state_q == FILL;
          state_q    <= REFILL;
        end
      end
    end
  end
  assign rand_en  = rand_en_q;
  assign rand_din = rand_din_q;
  assign rbg_busy = state_q != IDLE;
  assign rbg_err  = err_q;
endmodule

// File: tb/tb_auc_rbg.sv
// tb_auc_rbg: randomized and directed scoreboard bench for auc_rbg.
module tb_auc_rbg;
  localparam int WIDTH = 256;
  localparam int EW = 32;
  localparam int NW = WIDTH / EW;
  localparam int RCT_MAX = 4;
  typedef struct packed {
    logic             en;
    logic [WIDTH-1:0] din;
  } exp_t;
  logic             clk = 0;
  logic             rst, rbg_req, ent_vld, rand_vld;
  logic [EW-1:0]    ent_din;
  logic             rand_en, rbg_busy, rbg_err;
  logic [WIDTH-1:0] rand_din;
  int               n_tests = 0, n_fail = 0;
  exp_t             exp_q[$];
  bit               go = 0;
  int               mode = 0;
  logic [EW-1:0]    mq[$];
  logic [EW-1:0]    mlast = '0;
  int               run = 0;
  bit               merr = 0, men = 0;
  logic [WIDTH-1:0] mdin = '0;
  logic [EW-1:0]    pool[2] = '{32'hA5A5A5A5, 32'h0000_0007};

  auc_rbg #(.WIDTH(WIDTH), .EW(EW), .RCT_MAX(RCT_MAX)) dut (
    .clk(clk), .rst(rst), .rbg_req(rbg_req), .ent_vld(ent_vld), .ent_din(ent_din),
    .rand_vld(rand_vld), .rand_en(rand_en), .rand_din(rand_din),
    .rbg_busy(rbg_busy), .rbg_err(rbg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a candidate is simply the last NW accepted words, oldest in the MSBs.
  task automatic model(input bit rs, input bit rq, input bit v, input logic [EW-1:0] d, input bit r);
    int nr;
    logic [WIDTH-1:0] w;
    men = 0;
    if (rs) begin
      mode = 0; mq.delete(); run = 0; merr = 0;
      if (mdin != 0) begin
        exp_q.push_back('{en: 1'b0, din: '0});
        mdin = '0;
      end
    end else if (mode == 0) begin
      if (rq) begin
        mode = 1; mq.delete(); run = 0; merr = 0;
      end
    end else if (mode == 2 && r) begin
      mode = 0;
    end else if (v) begin
      nr = (run > 0 && d == mlast) ? run + 1 : 1;
      if (nr == RCT_MAX) begin
        mq.delete(); run = 0; merr = 1;
      end else begin
        mq.push_back(d); mlast = d; run = nr;
        if (mq.size() == NW) begin
          w = '0;
          foreach (mq[i]) w = (w << EW) | WIDTH'(mq[i]);
          men = (mode == 1);
          mdin = w;
          exp_q.push_back('{en: men, din: w});
          mq.delete();
          mode = 2;
        end
      end
    end
  endtask

  task automatic step(input bit rs, input bit rq, input bit v, input logic [EW-1:0] d, input bit r);
    rst = rs; rbg_req = rq; ent_vld = v; ent_din = d; rand_vld = r;
    model(rs, rq, v, d, r);
    @(posedge clk);
    #1;
    chk("rand_en", WIDTH'(rand_en), WIDTH'(men));
    chk("rbg_busy", WIDTH'(rbg_busy), WIDTH'(mode != 0));
    chk("rbg_err", WIDTH'(rbg_err), WIDTH'(merr));
    if (rs) chk("rst_din", rand_din, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
  endtask

  task automatic words(input logic [EW-1:0] base, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, base + EW'(i), 0);
  endtask

  // Monitor: pops an expectation whenever the DUT pulses rand_en or changes rand_din.
  initial begin
    logic [WIDTH-1:0] prev;
    exp_t e;
    wait (go);
    prev = '0;
    forever begin
      @(negedge clk);
      if (rand_en || rand_din !== prev) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", rand_din, prev);
          if (rand_din === prev) begin
            n_fail++;
            $display("FAIL sb_unexpected_en: got rand_en=1 expected no candidate");
          end
        end else begin
          e = exp_q.pop_front();
          chk("sb_en", WIDTH'(rand_en), WIDTH'(e.en));
          chk("sb_din", rand_din, e.din);
        end
        prev = rand_din;
      end
    end
  end

  initial begin
    rst = 1; rbg_req = 0; ent_vld = 0; ent_din = '0; rand_vld = 0;
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    go = 1;
    idle(2);
    // basic fill then refill and retake
    step(0, 1, 0, '0, 0);
    words(32'h1, 8);
    chk("basic_din", rand_din, 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
    words(32'h11, 8);
    chk("refill_din", rand_din, 256'h00000011_00000012_00000013_00000014_00000015_00000016_00000017_00000018);
    step(0, 0, 0, '0, 1);
    idle(2);
    // health failure at the limit
    step(0, 1, 0, '0, 0);
    words(32'h40, 3);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'hA5A5A5A5, 0);
    chk("hf_err", WIDTH'(rbg_err), WIDTH'(1));
    words(32'h100, 8);
    chk("hf_din", rand_din, 256'h00000100_00000101_00000102_00000103_00000104_00000105_00000106_00000107);
    step(0, 1, 0, '0, 0);
    chk("req_keeps_err", WIDTH'(rbg_err), WIDTH'(1));
    step(0, 0, 0, '0, 1);
    step(0, 1, 0, '0, 0);
    chk("req_clears_err", WIDTH'(rbg_err), WIDTH'(0));
    // run just under the limit
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h5555AAAA, 0);
    words(32'h200, 5);
    chk("under_err", WIDTH'(rbg_err), WIDTH'(0));
    // collision: rand_vld with the 8th refill word
    words(32'h300, 7);
    step(0, 0, 1, 32'h307, 1);
    chk("coll_din", rand_din, 256'h5555AAAA_5555AAAA_5555AAAA_00000200_00000201_00000202_00000203_00000204);
    idle(2);
    // gaps in the entropy stream
    step(0, 1, 0, '0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 32'h400 + EW'(i), 0);
      step(0, 0, 0, 32'hDEAD, 0);
    end
    step(0, 0, 0, '0, 1);
    // reset mid-candidate
    step(0, 1, 0, '0, 0);
    words(32'h500, 5);
    step(1, 0, 0, '0, 0);
    step(0, 1, 0, '0, 0);
    words(32'h600, 8);
    step(0, 0, 0, '0, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [EW-1:0] d;
      d = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 1)] : EW'($urandom);
      step($urandom_range(0, 499) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, d, $urandom_range(0, 24) == 0);
    end
    idle(3);
    chk("sb_drained", WIDTH'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
